// File: rtl/hit_multiplicity_trigger_pkg.sv
// Shared definitions for the hit-multiplicity trigger: FSM state encoding and
// the per-cycle hit-count clamp used by the input conditioning stage.
package hit_multiplicity_trigger_pkg;

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_ARMED    = 2'd1,
        ST_HOLDOFF  = 2'd2
    } trig_state_e;

    // A 16-channel popcount cannot legitimately exceed 16; larger codes are clamped.
    localparam logic [4:0] CLAMP_COUNT = 5'd16;

    function automatic logic [4:0] clamp_count(input logic [4:0] raw);
        return (raw > CLAMP_COUNT) ? CLAMP_COUNT : raw;
    endfunction

endpackage

// File: rtl/hit_multiplicity_trigger_if.sv
// Bus between the count_ones stage / slow control (master) and the
// multiplicity trigger (slave).
interface hit_multiplicity_trigger_if;
    logic        enable;
    logic        count_valid;
    logic [4:0]  count;
    logic [7:0]  threshold;
    logic [7:0]  win_sum;
    logic        trig;
    logic [7:0]  trig_mult;
    logic [15:0] trig_cnt;

    modport master (
        output enable, count_valid, count, threshold,
        input  win_sum, trig, trig_mult, trig_cnt
    );

    modport slave (
        input  enable, count_valid, count, threshold,
        output win_sum, trig, trig_mult, trig_cnt
    );
endinterface

// File: rtl/hit_multiplicity_trigger_mult_window_sum.sv
// Sliding window of the last WINDOW conditioned hit counts with a running sum
// (add newest, subtract oldest); clr empties the window in one cycle.
module mult_window_sum #(
    parameter int WINDOW = 4  // legal 1..15, so the sum never exceeds 240
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic [4:0] sample,
    output logic [7:0] sum
);

    logic [WINDOW-1:0][4:0] win_q, win_d;
    logic [7:0]             sum_q, sum_d;

    always_comb begin
        // NOTE: every _d gets a default first, so no path leaves it unassigned and no latch is inferred.
        win_d = win_q;
        sum_d = sum_q;
        if (clr) begin
            win_d = '0;
            sum_d = '0;
        end else begin
            win_d[0] = sample;
            for (int i = 1; i < WINDOW; i++) begin
                win_d[i] = win_q[i-1];
            end
            sum_d = sum_q + 8'(sample) - 8'(win_q[WINDOW-1]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments only here, so every flop samples pre-edge values.
        // NOTE: the window is a few flops rather than a RAM, so it is reset along with the sum.
        if (rst) begin
            win_q <= '0;
            sum_q <= '0;
        end else begin
            win_q <= win_d;
            sum_q <= sum_d;
        end
    end

    assign sum = sum_q;

endmodule

// File: rtl/hit_multiplicity_trigger.sv
// Multiplicity trigger: fires a one-cycle pulse when the windowed hit sum
// reaches threshold, then enforces HOLDOFF cycles of dead-time.
module hit_multiplicity_trigger
    import hit_multiplicity_trigger_pkg::*;
#(
    parameter int WINDOW  = 4,  // legal 1..15
    parameter int HOLDOFF = 8   // legal 1..255
) (
    input  logic                        clk,
    input  logic                        rst,
    hit_multiplicity_trigger_if.slave   bus
);

    localparam logic [7:0] HOLD_LOAD = 8'(HOLDOFF - 1);

    trig_state_e state_q, state_d;
    logic [7:0]  hold_q, hold_d;
    logic        trig_q, trig_d;
    logic [7:0]  mult_q, mult_d;
    logic [15:0] cnt_q, cnt_d;

    logic [4:0]  sample;
    logic        win_clr;
    logic [7:0]  win_sum;
    logic        fire;

    // The window is held empty while disabled and on the DISABLED->ARMED edge,
    // so ARMED always starts from a zero window.
    always_comb begin
        sample  = (bus.enable && bus.count_valid) ? clamp_count(bus.count) : 5'd0;
        win_clr = !bus.enable || (state_q == ST_DISABLED);
    end

    mult_window_sum #(.WINDOW(WINDOW)) u_window (
        .clk    (clk),
        .rst    (rst),
        .clr    (win_clr),
        .sample (sample),
        .sum    (win_sum)
    );

    assign fire = (state_q == ST_ARMED) && (bus.threshold != 8'd0) &&
                  (win_sum >= bus.threshold);

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        trig_d  = 1'b0;
        mult_d  = mult_q;
        cnt_d   = cnt_q;
        if (!bus.enable) begin
            state_d = ST_DISABLED;
            hold_d  = '0;
        end else begin
            unique case (state_q)
                ST_DISABLED: state_d = ST_ARMED;
                ST_ARMED: begin
                    if (fire) begin
                        trig_d  = 1'b1;
                        mult_d  = win_sum;
                        cnt_d   = cnt_q + 16'd1;
                        state_d = ST_HOLDOFF;
                        hold_d  = HOLD_LOAD;
                    end
                end
                ST_HOLDOFF: begin
                    // Loaded with HOLDOFF-1 and left at zero: exactly HOLDOFF dead cycles.
                    if (hold_q == 8'd0) state_d = ST_ARMED;
                    else                hold_d  = hold_q - 8'd1;
                end
                default: state_d = ST_DISABLED;
            endcase
        end
    end

    // rst is released synchronously to clk by the upstream reset tree.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_DISABLED;
            hold_q  <= '0;
            trig_q  <= 1'b0;
            mult_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            trig_q  <= trig_d;
            mult_q  <= mult_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.win_sum   = win_sum;
    assign bus.trig      = trig_q;
    assign bus.trig_mult = mult_q;
    assign bus.trig_cnt  = cnt_q;

endmodule

// File: tb/tb_hit_multiplicity_trigger.sv
// Self-checking bench: directed vector table, hand-written multi-cycle
// sequences and randomized traffic against a queue-based reference model.
module tb_hit_multiplicity_trigger;

    localparam int WINDOW  = 4;
    localparam int HOLDOFF = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hit_multiplicity_trigger_if bus();

    hit_multiplicity_trigger #(.WINDOW(WINDOW), .HOLDOFF(HOLDOFF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, exp);
        end
    endtask

    // Reference model: the window is the list of accepted samples since the
    // last clear; dead-time is measured from the edge number of the last trigger.
    int q_hist[$];
    int m_win, m_mult, m_cnt, edge_no, last_fire;
    bit m_trig, m_dis;

    function automatic void model_reset();
        q_hist.delete();
        m_win = 0; m_mult = 0; m_cnt = 0; m_trig = 0;
        m_dis = 1; edge_no = 0; last_fire = -1000;
    endfunction

    function automatic void model_step();
        bit fire = 0;
        int smp;
        edge_no++;
        if (!bus.enable) begin
            m_dis = 1;
            q_hist.delete();
            last_fire = -1000;
        end else if (m_dis) begin
            m_dis = 0;
            q_hist.delete();
        end else begin
            fire = (int'(bus.threshold) != 0) && (m_win >= int'(bus.threshold)) &&
                   (edge_no - last_fire > HOLDOFF);
            smp = !bus.count_valid ? 0 : ((int'(bus.count) > 16) ? 16 : int'(bus.count));
            q_hist.push_back(smp);
            if (q_hist.size() > WINDOW) void'(q_hist.pop_front());
        end
        if (fire) begin
            m_mult = m_win;
            m_cnt = (m_cnt + 1) % 65536;
            last_fire = edge_no;
        end
        m_trig = fire;
        m_win = 0;
        foreach (q_hist[i]) m_win += q_hist[i];
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("win_sum", bus.win_sum, m_win);
        check("trig", bus.trig, m_trig);
        check("trig_mult", bus.trig_mult, m_mult);
        check("trig_cnt", bus.trig_cnt, m_cnt);
    endtask

    task automatic drive(input bit en, input bit v, input logic [4:0] c, input logic [7:0] thr);
        bus.enable = en; bus.count_valid = v; bus.count = c; bus.threshold = thr;
    endtask

    typedef struct {
        bit         en;
        bit         v;
        logic [4:0] c;
        logic [7:0] thr;
        int         win;
        bit         trig;
        int         mult;
        int         cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(bit en, bit v, logic [4:0] c, logic [7:0] thr,
                                int win, bit trig, int mult, int cnt);
        vec_t x;
        x.en = en; x.v = v; x.c = c; x.thr = thr;
        x.win = win; x.trig = trig; x.mult = mult; x.cnt = cnt;
        vecs.push_back(x);
    endfunction

    initial begin
        #200us;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int trig_at[$];
        int saved_cnt, found, n_trig;

        drive(1'b0, 1'b0, 5'd0, 8'd0);
        #1;
        check("reset_win_sum", bus.win_sum, 0);
        check("reset_trig", bus.trig, 0);
        check("reset_trig_mult", bus.trig_mult, 0);
        check("reset_trig_cnt", bus.trig_cnt, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Single pulse, accumulation 2,2,2 at threshold 6, then clamp/qualify with threshold 0.
        add(1,0, 0,5,  0,0,0,0);
        add(1,1, 6,5,  6,0,0,0);
        add(1,0, 0,5,  6,1,6,1);
        add(1,0, 0,5,  6,0,6,1);
        add(1,0, 0,5,  6,0,6,1);
        add(1,0, 0,5,  0,0,6,1);
        for (int i = 0; i < 5; i++) add(1,0,0,6, 0,0,6,1);
        add(1,1, 2,6,  2,0,6,1);
        add(1,1, 2,6,  4,0,6,1);
        add(1,1, 2,6,  6,0,6,1);
        add(1,0, 0,6,  6,1,6,2);
        add(1,0, 0,6,  4,0,6,2);
        add(1,0, 0,6,  2,0,6,2);
        add(1,0, 0,6,  0,0,6,2);
        add(1,1,31,0, 16,0,6,2);
        add(1,0,16,0, 16,0,6,2);
        add(1,1,16,0, 32,0,6,2);
        add(1,0, 0,0, 32,0,6,2);
        add(1,0, 0,0, 16,0,6,2);
        add(1,0, 0,0, 16,0,6,2);
        add(1,0, 0,0,  0,0,6,2);
        foreach (vecs[i]) begin
            drive(vecs[i].en, vecs[i].v, vecs[i].c, vecs[i].thr);
            tick();
            check($sformatf("vec%0d_win_sum", i), bus.win_sum, vecs[i].win);
            check($sformatf("vec%0d_trig", i), bus.trig, vecs[i].trig);
            check($sformatf("vec%0d_trig_mult", i), bus.trig_mult, vecs[i].mult);
            check($sformatf("vec%0d_trig_cnt", i), bus.trig_cnt, vecs[i].cnt);
        end

        // Holdoff: saturated input must retrigger every HOLDOFF+1 cycles.
        for (int k = 0; k < 24; k++) begin
            if (k < 20) drive(1, 1, 5'd16, 8'd10);
            else        drive(1, 0, 5'd0, 8'd10);
            tick();
            if (bus.trig === 1'b1) trig_at.push_back(k);
        end
        check("holdoff_trig_count", trig_at.size(), 3);
        for (int i = 1; i < trig_at.size(); i++)
            check("holdoff_gap", trig_at[i] - trig_at[i-1], HOLDOFF + 1);
        check("holdoff_trig_cnt", bus.trig_cnt, 5);

        // Async reset between edges while in holdoff.
        drive(1, 1, 5'd16, 8'd0);
        #2 rst = 1'b1;
        #1;
        check("async_win_sum", bus.win_sum, 0);
        check("async_trig", bus.trig, 0);
        check("async_trig_mult", bus.trig_mult, 0);
        check("async_trig_cnt", bus.trig_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        n_trig = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (bus.trig === 1'b1) n_trig++;
        end
        check("thr0_no_trig", n_trig, 0);
        check("thr0_win_sum", bus.win_sum, 64);

        // Disable mid-holdoff: window clears, no residual dead-time, count retained.
        drive(1, 1, 5'd16, 8'd10);
        found = 0;
        for (int k = 0; k < 12 && !found; k++) begin
            tick();
            if (bus.trig === 1'b1) found = 1;
        end
        check("dis_first_trig_seen", found, 1);
        repeat (2) tick();
        saved_cnt = int'(bus.trig_cnt);
        drive(0, 1, 5'd16, 8'd10);
        tick();
        check("dis_win_cleared", bus.win_sum, 0);
        check("dis_cnt_retained", bus.trig_cnt, saved_cnt);
        drive(1, 1, 5'd16, 8'd10);
        found = 0;
        for (int k = 0; k < 3 && !found; k++) begin
            tick();
            if (bus.trig === 1'b1) found = 1;
        end
        check("dis_retrig_within_3", found, 1);
        check("dis_cnt_after_retrig", bus.trig_cnt, (saved_cnt + 1) % 65536);

        // Randomized traffic against the model.
        for (int k = 0; k < 400; k++) begin
            bus.enable      = ($urandom_range(0, 24) != 0);
            bus.count_valid = 1'($urandom_range(0, 1));
            bus.count       = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 15) == 0)
                bus.threshold = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(1, 80));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
